// File: rtl/i2s_tx_sequencer_if.sv
// Sample handshake bundle between the PCM sources and the I2S transmit sequencer.
interface i2s_tx_sequencer_if #(
    parameter int unsigned DATA_W = 24
) ();
    logic [DATA_W-1:0] left_data;
    logic              left_valid;
    logic              left_ready;
    logic [DATA_W-1:0] right_data;
    logic              right_valid;
    logic              right_ready;

    modport master (
        output left_data, left_valid, right_data, right_valid,
        input  left_ready, right_ready
    );

    modport slave (
        input  left_data, left_valid, right_data, right_valid,
        output left_ready, right_ready
    );
endinterface

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: one-deep L/R holding registers, slot-aligned shift
// register with the I2S one-bit delay, frame pulse and sticky underrun flags.
module i2s_tx_sequencer #(
    parameter int unsigned DATA_W = 24
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic                bclk_in,
    input  logic                lrclk_in,
    input  logic                enable,
    input  logic                underrun_clr,
    i2s_tx_sequencer_if.slave   smp,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun_l,
    output logic                underrun_r
);

    localparam int unsigned SHIFT_W = 32;
    localparam int unsigned CNT_W   = 5;
    // Zero padding below the sample; the leading zero is the I2S delay bit.
    localparam int unsigned PAD_W   = SHIFT_W - 1 - DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN
    } state_e;

    state_e               state_q, state_d;
    logic                 bclk_q;
    logic                 lr_s_q, lr_s_d;
    logic                 bfall;
    logic                 boundary;
    logic                 slot_load;
    logic [DATA_W-1:0]    l_data_q, l_data_d;
    logic [DATA_W-1:0]    r_data_q, r_data_d;
    logic                 l_full_q, l_full_d;
    logic                 r_full_q, r_full_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 sdata_q, sdata_d;
    logic                 frame_start_q, frame_start_d;
    logic                 ur_l_q, ur_l_d;
    logic                 ur_r_q, ur_r_d;
    logic                 set_l, set_r;
    logic                 consume_l, consume_r;

    // Next-state logic: edge detect, FSM, slot loading, holding registers, flags.
    always_comb begin
        bfall         = bclk_q & ~bclk_in;
        boundary      = bfall & (lrclk_in != lr_s_q);
        state_d       = state_q;
        lr_s_d        = bfall ? lrclk_in : lr_s_q;
        l_data_d      = l_data_q;
        r_data_d      = r_data_q;
        l_full_d      = l_full_q;
        r_full_d      = r_full_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        frame_start_d = 1'b0;
        slot_load     = 1'b0;
        set_l         = 1'b0;
        set_r         = 1'b0;
        consume_l     = 1'b0;
        consume_r     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                shift_d   = '0;
                bit_cnt_d = '0;
                if (enable) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (boundary && !lrclk_in) begin
                    state_d   = ST_RUN;
                    slot_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    if (enable) begin
                        slot_load = 1'b1;
                    end else begin
                        // Stop cleanly at a slot edge; held samples stay put.
                        state_d   = ST_IDLE;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end
                end else if (bfall) begin
                    shift_d   = {shift_q[SHIFT_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (slot_load) begin
            bit_cnt_d = '0;
            if (!lrclk_in) begin
                frame_start_d = 1'b1;
                if (l_full_q) begin
                    shift_d   = SHIFT_W'(l_data_q) << PAD_W;
                    consume_l = 1'b1;
                end else begin
                    shift_d = '0;
                    set_l   = 1'b1;
                end
            end else begin
                if (r_full_q) begin
                    shift_d   = SHIFT_W'(r_data_q) << PAD_W;
                    consume_r = 1'b1;
                end else begin
                    shift_d = '0;
                    set_r   = 1'b1;
                end
            end
        end

        // Consume needs full and a write needs empty, so they never collide.
        if (consume_l) begin
            l_full_d = 1'b0;
        end
        if (smp.left_valid && !l_full_q) begin
            l_full_d = 1'b1;
            l_data_d = smp.left_data;
        end
        if (consume_r) begin
            r_full_d = 1'b0;
        end
        if (smp.right_valid && !r_full_q) begin
            r_full_d = 1'b1;
            r_data_d = smp.right_data;
        end

        sdata_d = (state_d == ST_RUN) ? shift_d[SHIFT_W-1] : 1'b0;
        ur_l_d  = set_l | (ur_l_q & ~underrun_clr);
        ur_r_d  = set_r | (ur_r_q & ~underrun_clr);
    end

    // State and datapath registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            bclk_q        <= 1'b0;
            lr_s_q        <= 1'b0;
            l_data_q      <= '0;
            r_data_q      <= '0;
            l_full_q      <= 1'b0;
            r_full_q      <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            ur_l_q        <= 1'b0;
            ur_r_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bclk_q        <= bclk_in;
            lr_s_q        <= lr_s_d;
            l_data_q      <= l_data_d;
            r_data_q      <= r_data_d;
            l_full_q      <= l_full_d;
            r_full_q      <= r_full_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            ur_l_q        <= ur_l_d;
            ur_r_q        <= ur_r_d;
        end
    end

    assign smp.left_ready  = ~l_full_q;
    assign smp.right_ready = ~r_full_q;
    assign sdata           = sdata_q;
    assign frame_start     = frame_start_q;
    assign underrun_l      = ur_l_q;
    assign underrun_r      = ur_r_q;

endmodule

// File: doc/i2s_tx_sequencer.md
# i2s_tx_sequencer

Sequences left/right PCM samples onto the I2S serial data line in the 12.288 MHz `clock_in` domain. The 3.072 MHz bit clock and 48 kHz word clock come in as registered, `clock_in`-synchronous levels from the audio timing generator. Two sample sources, left and right, each get a one-deep holding register behind a valid/ready handshake. The block moves each held sample into a shift register at its slot boundary, serialises it MSB-first with the standard I2S one-bit delay, and flags underruns.

## Interface
- DATA_W, 24, sample width in bits; legal range 8..31
- clock_in  in  1  12.288 MHz system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- bclk_in  in  1  3.072 MHz bit clock level, synchronous to clock_in
- lrclk_in  in  1  48 kHz word clock level, synchronous to clock_in; 0 = left, 1 = right
- enable  in  1  run request
- left_data  in  DATA_W  left sample, two's complement
- left_valid  in  1  left sample offered
- left_ready  out  1  left holding register empty
- right_data / right_valid / right_ready  same meanings for the right channel
- underrun_clr  in  1  clears both sticky underrun flags
- sdata  out  1  I2S serial data
- frame_start  out  1  one-cycle pulse at each left-slot boundary in RUN
- underrun_l, underrun_r  out  1  sticky underrun flags

## Operation
- Edge detection: bclk_q holds the value of bclk_in from the previous cycle. bfall = bclk_q & ~bclk_in.
- On every bfall, lrclk_in is sampled into lr_s. boundary = bfall & (lrclk_in != lr_s).
- Holding registers, one per channel:
  - ready = ~full.
  - valid & ready loads the register and sets full.
  - In RUN, the register is consumed at its own channel's boundary: full clears in that cycle.
  - A write in the same cycle as an empty-register boundary is accepted, but it serves the next slot of that channel, not the current one.
- States: IDLE, SYNC, RUN.
  - IDLE: sdata = 0; waits for enable = 1, then goes to SYNC.
  - SYNC: waits for a boundary where lrclk_in = 0 (left start), then goes to RUN and processes that boundary as a RUN boundary.
  - RUN, at each boundary:
    - Channel = new lrclk_in.
    - If that channel's holding register is full, load it into shift[31:0] = {1'b0, data, zeros}.
    - Otherwise load zeros and set that channel's underrun flag.
    - bit_cnt = 0.
    - On a left boundary, pulse frame_start.
  - RUN, at each non-boundary bfall: shift left by one, bit_cnt += 1 (5 bits, wraps at 31).
  - sdata = shift[31] registered. The first slot bit is the 0 delay bit, bits 1..DATA_W are MSB..LSB of the sample, and the remaining bits are 0.
- Enable deassert in RUN: the current slot completes. At the next boundary the FSM goes to IDLE, that boundary consumes nothing, and sdata = 0. Holding registers keep their contents.
- Underrun flags: set only in RUN. underrun_clr clears both. If set and clear happen in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-slot) forces:
  - state = IDLE
  - sdata = 0, frame_start = 0
  - underrun_l = underrun_r = 0
  - holding registers empty, so left_ready = right_ready = 1
  - shift = 0, bit_cnt = 0, bclk_q = 0, lr_s = 0

## Timing
- Nominal ATG relation:
  - bit period = 4 clock_in cycles
  - slot = 32 bits = 128 cycles
  - frame = 256 cycles
- sdata updates on the clock_in edge that ends the bfall cycle, i.e. one cycle after bclk_in falls. It is stable two cycles before the next bclk_in rise.
- frame_start is high for exactly the bfall cycle's following clock, i.e. it is registered with sdata.
- Ready latency:
  - ready rises the cycle after the consuming boundary.
  - ready falls the cycle after an accepted write.
- Minimum refill window is one slot (128 cycles) per channel; a write within it never underruns.
- The block does not require a fixed bclk/lrclk phase. It only requires lrclk_in to be stable across each bfall sample.

## Test plan
- Reset then enable, drive ATG clocks, preload L = 24'hA5A5A5 and R = 24'h5A5A5A → first frame_start at the first left boundary. Left slot sdata = 0, then A5A5A5 MSB-first, then 7 zeros; the right slot carries 5A5A5A likewise. No underrun.
- Supply R only, never L → left slot all zeros, underrun_l = 1, underrun_r = 0. Pulse underrun_clr → underrun_l = 0, then 1 again at the next left boundary.
- Hold left_valid with new data each slot → left_ready asserts once per frame, one cycle after the left boundary. Every sample appears exactly once, in order.
- Deassert enable mid right slot → the right slot completes intact, then sdata = 0, frame_start stops, and held data is retained. Re-enable → transmission resumes only from the next left boundary.
- Assert reset_n = 0 at bit 10 of a left slot → all outputs reset immediately (asynchronously), and both ready = 1. After release with enable = 1, the FSM re-syncs to a left boundary.
- Write L in the exact boundary cycle while L is empty → underrun_l = 1, zeros in this slot, and the written sample appears in the next left slot.
